// File: rtl/ulpi_pkg.sv
// Shared ULPI constants, FSM state encoding and RX CMD field layout for the link controller.
package ulpi_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned RX_COUNT_W = 16;

   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;

   localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
   localparam logic [5:0] ADDR_VID_LOW   = 6'h00;

   localparam int unsigned RXCMD_LINESTATE_LSB = 0;
   localparam int unsigned RXCMD_VBUS_LSB      = 2;
   localparam int unsigned RXCMD_RXEVENT_LSB   = 4;

   typedef enum logic [3:0] {
      ST_PHY_RST,
      ST_STARTUP,
      ST_WR_CMD,
      ST_WR_DATA,
      ST_WR_STP,
      ST_RD_CMD,
      ST_RD_TURN1,
      ST_RD_DATA,
      ST_RD_TURN2,
      ST_IDLE,
      ST_WAIT_BUS
   } state_e;

   typedef struct packed {
      logic [1:0] rxevent;
      logic [1:0] vbus;
      logic [1:0] linestate;
   } rxcmd_t;

   function automatic logic [DATA_W-1:0] tx_cmd(input logic [1:0] prefix, input logic [5:0] addr);
      return {prefix, addr};
   endfunction

endpackage

// File: rtl/ulpi_if.sv
// ULPI data bus between link (master) and PHY (slave); clock and PHY reset stay outside.
interface ulpi_if;
   import ulpi_pkg::*;

   logic [DATA_W-1:0] ulpi_data_read;
   logic [DATA_W-1:0] ulpi_data_write;
   logic [DATA_W-1:0] ulpi_data_writeEnable;
   logic              ulpi_direction;
   logic              ulpi_stp;
   logic              ulpi_nxt;

   modport master (
      input  ulpi_data_read,
      input  ulpi_direction,
      input  ulpi_nxt,
      output ulpi_data_write,
      output ulpi_data_writeEnable,
      output ulpi_stp
   );

   modport slave (
      output ulpi_data_read,
      output ulpi_direction,
      output ulpi_nxt,
      input  ulpi_data_write,
      input  ulpi_data_writeEnable,
      input  ulpi_stp
   );

endinterface

// File: rtl/ulpi_rxcmd_decoder.sv
// Tracks bus direction history, latches RX CMD fields and counts received USB data bytes.
module ulpi_rxcmd_decoder
   import ulpi_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_dir,
   input  logic                  i_nxt,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_enable,
   input  logic                  i_suppress,
   output logic                  o_dir_q,
   output rxcmd_t                o_rxcmd,
   output logic [RX_COUNT_W-1:0] o_rx_byte_count
);

   logic                  r_dir_q;
   rxcmd_t                r_rxcmd;
   logic [RX_COUNT_W-1:0] r_rx_byte_count;
   logic                  w_data_cycle;
   logic                  w_unused_hi;

   // The first cycle with dir high is turnaround; only later cycles carry data.
   assign w_data_cycle = i_dir && r_dir_q;
   assign w_unused_hi  = ^i_data[DATA_W-1:6];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dir_q         <= 1'b0;
         r_rxcmd         <= '0;
         r_rx_byte_count <= '0;
      end else begin
         r_dir_q <= i_dir;
         if (i_enable && w_data_cycle) begin
            if (i_nxt) begin
               r_rx_byte_count <= r_rx_byte_count + RX_COUNT_W'(1);
            end else if (!i_suppress) begin
               r_rxcmd.linestate <= i_data[RXCMD_LINESTATE_LSB +: 2];
               r_rxcmd.vbus      <= i_data[RXCMD_VBUS_LSB +: 2];
               r_rxcmd.rxevent   <= i_data[RXCMD_RXEVENT_LSB +: 2];
            end
         end
      end
   end

   assign o_dir_q         = r_dir_q;
   assign o_rxcmd         = r_rxcmd;
   assign o_rx_byte_count = r_rx_byte_count;

endmodule

// File: rtl/usb_ulpi_link_top.sv
// ULPI link top: PHY reset, Function Control write, Vendor ID Low readback, RX CMD decode and LEDs.
module usb_ulpi_link_top
   import ulpi_pkg::*;
#(
   parameter int unsigned       PHY_RESET_CYCLES = 60,
   parameter int unsigned       STARTUP_CYCLES   = 32,
   parameter logic [DATA_W-1:0] FUNC_CTRL_VALUE  = 8'h45,
   parameter logic [DATA_W-1:0] EXPECTED_VID_LOW = 8'h24,
   parameter int unsigned       HEARTBEAT_BITS   = 26
) (
   input  logic     ulpi_clk,
   input  logic     reset,
   ulpi_if.master   ulpi,
   output logic     ulpi_reset_,
   output logic     led0,
   output logic     led1,
   output logic     led2,
   output logic     led3
);

   localparam int unsigned CNT_MAX = (PHY_RESET_CYCLES > STARTUP_CYCLES) ? PHY_RESET_CYCLES : STARTUP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [DATA_W-1:0] WR_CMD_BYTE = tx_cmd(TXCMD_REGW, ADDR_FUNC_CTRL);
   localparam logic [DATA_W-1:0] RD_CMD_BYTE = tx_cmd(TXCMD_REGR, ADDR_VID_LOW);

   state_e                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_ulpi_rst_n;
   logic [DATA_W-1:0]       r_data_write;
   logic [DATA_W-1:0]       r_we;
   logic                    r_stp;
   logic                    r_wr_done;
   logic                    r_init_done;
   logic [DATA_W-1:0]       r_vid_low;
   logic                    r_vid_valid;
   logic                    r_led3;
   logic [HEARTBEAT_BITS-1:0] r_hb;

   logic                    w_dir;
   logic                    w_nxt;
   logic                    w_dir_q;
   logic                    w_bus_free;
   logic                    w_rx_enable;
   logic                    w_rx_suppress;
   rxcmd_t                  w_rxcmd;
   logic [RX_COUNT_W-1:0]   w_rx_byte_count;
   logic                    w_unused_rx;

   assign w_dir         = ulpi.ulpi_direction;
   assign w_nxt         = ulpi.ulpi_nxt;
   assign w_bus_free    = !w_dir && !w_dir_q;
   assign w_rx_enable   = (r_state != ST_PHY_RST) && (r_state != ST_STARTUP);
   assign w_rx_suppress = (r_state == ST_RD_DATA);
   assign w_unused_rx   = ^{w_rxcmd.linestate[1], w_rxcmd.vbus, w_rxcmd.rxevent, w_rx_byte_count};

   ulpi_rxcmd_decoder u_rx (
      .clk             (ulpi_clk),
      .reset           (reset),
      .i_dir           (w_dir),
      .i_nxt           (w_nxt),
      .i_data          (ulpi.ulpi_data_read),
      .i_enable        (w_rx_enable),
      .i_suppress      (w_rx_suppress),
      .o_dir_q         (w_dir_q),
      .o_rxcmd         (w_rxcmd),
      .o_rx_byte_count (w_rx_byte_count)
   );

   // Init sequencer; data_write holds the byte belonging to the state being entered.
   always_ff @(posedge ulpi_clk) begin
      if (reset) begin
         r_state      <= ST_PHY_RST;
         r_cnt        <= '0;
         r_ulpi_rst_n <= 1'b0;
         r_data_write <= '0;
         r_we         <= '0;
         r_stp        <= 1'b0;
         r_wr_done    <= 1'b0;
         r_init_done  <= 1'b0;
         r_vid_low    <= '0;
         r_vid_valid  <= 1'b0;
         r_led3       <= 1'b0;
      end else begin
         r_stp  <= 1'b0;
         r_we   <= w_bus_free ? {DATA_W{1'b1}} : '0;
         r_led3 <= r_vid_valid && (r_vid_low == EXPECTED_VID_LOW);
         unique case (r_state)
            ST_PHY_RST: begin
               if (r_cnt == CNT_W'(PHY_RESET_CYCLES - 1)) begin
                  r_ulpi_rst_n <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= ST_STARTUP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_STARTUP: begin
               if (r_cnt != CNT_W'(STARTUP_CYCLES - 1)) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (w_bus_free) begin
                  r_state      <= ST_WR_CMD;
                  r_data_write <= WR_CMD_BYTE;
               end
            end
            ST_WR_CMD: begin
               if (w_dir) begin
                  r_state      <= ST_WAIT_BUS;
                  r_data_write <= '0;
               end else if (w_nxt) begin
                  r_state      <= ST_WR_DATA;
                  r_data_write <= FUNC_CTRL_VALUE;
               end
            end
            ST_WR_DATA: begin
               if (w_dir) begin
                  r_state      <= ST_WAIT_BUS;
                  r_data_write <= '0;
               end else if (w_nxt) begin
                  r_state      <= ST_WR_STP;
                  r_data_write <= '0;
                  r_stp        <= 1'b1;
                  r_wr_done    <= 1'b1;
               end
            end
            ST_WR_STP: begin
               r_state      <= ST_RD_CMD;
               r_data_write <= RD_CMD_BYTE;
            end
            ST_RD_CMD: begin
               if (w_dir) begin
                  r_state      <= ST_WAIT_BUS;
                  r_data_write <= '0;
               end else if (w_nxt) begin
                  r_state      <= ST_RD_TURN1;
                  r_data_write <= '0;
               end
            end
            ST_RD_TURN1: begin
               if (w_dir) r_state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (w_nxt) begin
                  r_state <= ST_WAIT_BUS;
               end else if (w_dir) begin
                  r_vid_low   <= ulpi.ulpi_data_read;
                  r_vid_valid <= 1'b1;
                  r_state     <= ST_RD_TURN2;
               end
            end
            ST_RD_TURN2: begin
               if (!w_dir) begin
                  r_state     <= ST_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_WAIT_BUS: begin
               // Retry whichever register transaction was interrupted.
               if (w_bus_free) begin
                  r_state      <= r_wr_done ? ST_RD_CMD : ST_WR_CMD;
                  r_data_write <= r_wr_done ? RD_CMD_BYTE : WR_CMD_BYTE;
               end
            end
            default: begin
               r_state <= ST_PHY_RST;
            end
         endcase
      end
   end

   always_ff @(posedge ulpi_clk) begin
      if (reset) r_hb <= '0;
      else       r_hb <= r_hb + HEARTBEAT_BITS'(1);
   end

   assign ulpi.ulpi_data_write       = r_data_write;
   assign ulpi.ulpi_data_writeEnable = r_we;
   assign ulpi.ulpi_stp              = r_stp;
   assign ulpi_reset_                = r_ulpi_rst_n;
   assign led0                       = r_hb[HEARTBEAT_BITS-1];
   assign led1                       = r_init_done;
   assign led2                       = w_rxcmd.linestate[0];
   assign led3                       = r_led3;

endmodule

// File: tb/tb_usb_ulpi_link_top.sv
// Bench for usb_ulpi_link_top: behavioural PHY with scoreboard queues for bus traffic.
module tb_usb_ulpi_link_top;
   import ulpi_pkg::*;

   logic ulpi_clk = 1'b0;
   logic reset;
   logic ulpi_reset_;
   logic led0, led1, led2, led3;

   ulpi_if ulpi ();

   usb_ulpi_link_top #(.HEARTBEAT_BITS(4)) u_dut (
      .ulpi_clk    (ulpi_clk),
      .reset       (reset),
      .ulpi        (ulpi),
      .ulpi_reset_ (ulpi_reset_),
      .led0        (led0),
      .led1        (led1),
      .led2        (led2),
      .led3        (led3)
   );

   always #5 ulpi_clk = ~ulpi_clk;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   logic [7:0] we_exp_q[$];

   logic [7:0] ab_we_rise;
   logic [7:0] ab_we_fall;
   logic       ab_led2;

   task automatic tick();
      @(posedge ulpi_clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge ulpi_clk);
      #1;
      reset = 1'b1;
      ulpi.ulpi_direction = 1'b0;
      ulpi.ulpi_nxt = 1'b0;
      ulpi.ulpi_data_read = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   // PHY model: accepts each TX byte with nxt on its 2nd cycle, answers the register read.
   task automatic phy_session(input logic [7:0] vid, input bit do_abort, output bit tmo);
      int         age = 0;
      int         phase = 0;
      logic [7:0] prev = 8'h00;
      bit         prev_nxt = 1'b0;
      bit         aborted = 1'b0;
      bit         done = 1'b0;
      tmo = 1'b1;
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         tick();
         if (ulpi.ulpi_stp === 1'b1) obs_q.push_back({1'b1, ulpi.ulpi_data_write});
         case (phase)
            0: begin
               if (ulpi.ulpi_data_writeEnable === 8'hFF && ulpi.ulpi_data_write !== 8'h00) begin
                  if (prev_nxt || ulpi.ulpi_data_write !== prev) age = 1;
                  else age++;
               end else begin
                  age = 0;
               end
               prev = ulpi.ulpi_data_write;
               if (do_abort && !aborted && prev == 8'h45 && age == 1) begin
                  aborted = 1'b1;
                  prev_nxt = 1'b0;
                  ulpi.ulpi_nxt = 1'b0;
                  ulpi.ulpi_direction = 1'b1;
                  phase = 10;
               end else begin
                  prev_nxt = (age == 2);
                  ulpi.ulpi_nxt = prev_nxt;
                  if (prev_nxt) begin
                     obs_q.push_back({1'b0, prev});
                     if (prev == 8'hC0) phase = 1;
                  end
               end
            end
            1: begin ulpi.ulpi_nxt = 1'b0; ulpi.ulpi_direction = 1'b1; phase = 2; end
            2: begin ulpi.ulpi_data_read = vid; phase = 3; end
            3: begin ulpi.ulpi_direction = 1'b0; ulpi.ulpi_data_read = 8'h00; phase = 4; end
            4: begin tmo = 1'b0; done = 1'b1; end
            10: begin ab_we_rise = ulpi.ulpi_data_writeEnable; ulpi.ulpi_data_read = 8'h01; phase = 11; end
            11: begin ab_led2 = led2; ulpi.ulpi_direction = 1'b0; ulpi.ulpi_data_read = 8'h00; phase = 12; end
            12: begin ab_we_fall = ulpi.ulpi_data_writeEnable; phase = 0; end
            default: phase = 0;
         endcase
      end
   endtask

   task automatic test_reset();
      int n;
      @(posedge ulpi_clk);
      #1;
      reset = 1'b1;
      ulpi.ulpi_direction = 1'b0;
      ulpi.ulpi_nxt = 1'b0;
      ulpi.ulpi_data_read = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (ulpi.ulpi_data_writeEnable !== 8'h00) begin
            n_err++;
            $display("FAIL reset_we cycle %0d: got %h want 00", i, ulpi.ulpi_data_writeEnable);
         end
      end
      n_vec++;
      if ({ulpi_reset_, ulpi.ulpi_data_write, ulpi.ulpi_stp, led0, led1, led2, led3} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_outputs: rst_n=%b dw=%h stp=%b leds=%b%b%b%b want all 0",
                  ulpi_reset_, ulpi.ulpi_data_write, ulpi.ulpi_stp, led3, led2, led1, led0);
      end
      reset = 1'b0;
      n = 0;
      while (n < 200) begin
         tick();
         n++;
         if (ulpi_reset_ === 1'b1) break;
      end
      n_vec++;
      if (n != 60) begin
         n_err++;
         $display("FAIL phy_reset_len: got %0d cycles want 60", n);
      end
   endtask

   task automatic test_heartbeat();
      logic exp_led0;
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         tick();
         exp_led0 = ((n / 8) % 2) == 1;
         n_vec++;
         if (led0 !== exp_led0) begin
            n_err++;
            $display("FAIL heartbeat cycle %0d: got %b want %b", n, led0, exp_led0);
         end
      end
   endtask

   task automatic test_init(input logic [7:0] vid, input logic exp_led3);
      bit tmo;
      logic [8:0] e, o;
      do_reset();
      exp_q.push_back(9'h084);
      exp_q.push_back(9'h045);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h0C0);
      phy_session(vid, 1'b0, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL init_timeout vid=%h: got timeout want done", vid); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL init_stream vid=%h: got nothing want %h", vid, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL init_stream vid=%h: got %h want %h", vid, o, e); end
         end
      end
      n_vec++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL init_extra vid=%h: got %0d extra items want 0", vid, obs_q.size());
      end
      tick();
      n_vec++;
      if ({led1, led2, led3} !== {1'b1, 1'b0, exp_led3}) begin
         n_err++;
         $display("FAIL init_leds vid=%h: got led1=%b led2=%b led3=%b want 1 0 %b", vid, led1, led2, led3, exp_led3);
      end
   endtask

   task automatic test_abort();
      bit tmo;
      logic [8:0] e, o;
      do_reset();
      ab_we_rise = 8'hXX;
      ab_we_fall = 8'hXX;
      ab_led2 = 1'bx;
      exp_q.push_back(9'h084);
      exp_q.push_back(9'h084);
      exp_q.push_back(9'h045);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h0C0);
      phy_session(8'h24, 1'b1, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL abort_timeout: got timeout want done"); end
      n_vec++;
      if (ab_we_rise !== 8'h00) begin n_err++; $display("FAIL abort_we_rise: got %h want 00", ab_we_rise); end
      n_vec++;
      if (ab_led2 !== 1'b1) begin n_err++; $display("FAIL abort_led2: got %b want 1", ab_led2); end
      n_vec++;
      if (ab_we_fall !== 8'h00) begin n_err++; $display("FAIL abort_we_fall: got %h want 00", ab_we_fall); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL abort_stream: got nothing want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL abort_stream: got %h want %h", o, e); end
         end
      end
      n_vec++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL abort_extra: got %0d extra items want 0", obs_q.size());
      end
      tick();
      n_vec++;
      if ({led1, led3} !== 2'b11) begin
         n_err++;
         $display("FAIL abort_leds: got led1=%b led3=%b want 1 1", led1, led3);
      end
   endtask

   task automatic test_rx_burst();
      bit tmo;
      logic [7:0] got_we, want_we;
      // {dir, nxt, data, writeEnable expected after the edge that samples this cycle}
      logic [17:0] burst [7] = '{
         {1'b1, 1'b0, 8'h00, 8'h00},
         {1'b1, 1'b0, 8'h02, 8'h00},
         {1'b1, 1'b1, 8'hA1, 8'h00},
         {1'b1, 1'b1, 8'hB2, 8'h00},
         {1'b1, 1'b1, 8'hC3, 8'h00},
         {1'b0, 1'b0, 8'h00, 8'h00},
         {1'b0, 1'b0, 8'h00, 8'hFF}
      };
      do_reset();
      phy_session(8'h24, 1'b0, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL burst_init_timeout: got timeout want done"); end
      repeat (2) tick();
      we_exp_q.delete();
      for (int i = 0; i < 7; i++) begin
         ulpi.ulpi_direction = burst[i][17];
         ulpi.ulpi_nxt       = burst[i][16];
         ulpi.ulpi_data_read = burst[i][15:8];
         we_exp_q.push_back(burst[i][7:0]);
         tick();
         got_we  = ulpi.ulpi_data_writeEnable;
         want_we = we_exp_q.pop_front();
         n_vec++;
         if (got_we !== want_we) begin
            n_err++;
            $display("FAIL burst_we step %0d: got %h want %h", i, got_we, want_we);
         end
      end
      n_vec++;
      if (u_dut.w_rx_byte_count !== 16'd3) begin
         n_err++;
         $display("FAIL burst_count: got %0d want 3", u_dut.w_rx_byte_count);
      end
      n_vec++;
      if (u_dut.w_rxcmd.linestate !== 2'b10 || led2 !== 1'b0) begin
         n_err++;
         $display("FAIL burst_linestate: got %b led2=%b want 10 led2=0", u_dut.w_rxcmd.linestate, led2);
      end
   endtask

   initial begin
      reset = 1'b1;
      ulpi.ulpi_direction = 1'b0;
      ulpi.ulpi_nxt = 1'b0;
      ulpi.ulpi_data_read = 8'h00;
      test_reset();
      test_heartbeat();
      test_init(8'h24, 1'b1);
      test_init(8'h11, 1'b0);
      test_abort();
      test_rx_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
